// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap entry / mret sequencer driving csr_regs writes and pc redirect
// Turns ecall, mret or a timer interrupt into a fixed CSR write sequence and a jump.

module trap_ctrl #(
  parameter int               XLEN        = 64,
  parameter logic [XLEN-1:0]  CAUSE_ECALL = 64'd11,
  parameter logic [XLEN-1:0]  CAUSE_TIMER = 64'h8000_0000_0000_0007
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ecall_i,
  input  logic             mret_i,
  input  logic [XLEN-1:0]  inst_pc_i,
  input  logic             timer_irq_i,
  input  logic             mstatus_mie_i,
  input  logic [XLEN-1:0]  csr_rdata_i,
  output logic [11:0]      csr_raddr_o,
  output logic [11:0]      csr_waddr_o,
  output logic [XLEN-1:0]  csr_wdata_o,
  output logic             csr_wen_o,
  output logic             hold_o,
  output logic             busy_o,
  output logic             jump_flag_o,
  output logic [XLEN-1:0]  jump_addr_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_MEPC,
    S_T_MCAUSE,
    S_T_MSTATUS,
    S_T_JUMP,
    S_R_MSTATUS,
    S_R_JUMP
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic            req_hold;
  logic [XLEN-1:0] ms_trap;
  logic [XLEN-1:0] ms_ret;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // mstatus rewrites: trap saves MIE into MPIE and enters M-mode; mret restores MIE.
  always_comb begin
    ms_trap      = csr_rdata_i;
    ms_trap[7]   = csr_rdata_i[3];
    ms_trap[3]   = 1'b0;
    ms_trap[12:11] = 2'b11;
    ms_ret       = csr_rdata_i;
    ms_ret[3]    = csr_rdata_i[7];
    ms_ret[7]    = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    req_hold    = 1'b0;
    csr_raddr_o = '0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    csr_wen_o   = 1'b0;
    jump_flag_o = 1'b0;
    jump_addr_o = '0;
    unique case (state_q)
      S_IDLE: begin
        if (ecall_i) begin
          req_hold = 1'b1;
          epc_d    = inst_pc_i;
          cause_d  = CAUSE_ECALL;
          state_d  = S_T_MEPC;
        end else if (mret_i) begin
          req_hold = 1'b1;
          state_d  = S_R_MSTATUS;
        end else if (timer_irq_i && mstatus_mie_i) begin
          req_hold = 1'b1;
          epc_d    = inst_pc_i;
          cause_d  = CAUSE_TIMER;
          state_d  = S_T_MEPC;
        end
      end
      S_T_MEPC: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = ADDR_MEPC;
        csr_wdata_o = epc_q;
        state_d     = S_T_MCAUSE;
      end
      S_T_MCAUSE: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = ADDR_MCAUSE;
        csr_wdata_o = cause_q;
        state_d     = S_T_MSTATUS;
      end
      S_T_MSTATUS: begin
        csr_raddr_o = ADDR_MSTATUS;
        csr_wen_o   = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = ms_trap;
        state_d     = S_T_JUMP;
      end
      S_T_JUMP: begin
        csr_raddr_o = ADDR_MTVEC;
        jump_flag_o = 1'b1;
        jump_addr_o = {csr_rdata_i[XLEN-1:2], 2'b00};
        state_d     = S_IDLE;
      end
      S_R_MSTATUS: begin
        csr_raddr_o = ADDR_MSTATUS;
        csr_wen_o   = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = ms_ret;
        state_d     = S_R_JUMP;
      end
      S_R_JUMP: begin
        csr_raddr_o = ADDR_MEPC;
        jump_flag_o = 1'b1;
        jump_addr_o = csr_rdata_i;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);
  // Gate the detect-cycle stall with reset so every output is 0 while rst is low.
  assign hold_o = busy_o | (req_hold & rst);

endmodule
